// File: rtl/ysyx_24080014_pkg.sv
// Shared types and constants for the ysyx_24080014 instruction fetch unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_24080014_pkg;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_ADDR = 3'd1,
        IFU_DATA = 3'd2,
        IFU_HOLD = 3'd3,
        IFU_WAIT = 3'd4
    } ifu_state_t;

    // addi x0, x0, 0 -- handed to the decoder whenever a fetch fails
    localparam logic [31:0] NOP_INST  = 32'h0000_0013;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    // Word-aligned bus address for a given pc (low two bits cleared)
    function automatic logic [31:0] fetch_addr(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/ysyx_24080014_ifu_wdog.sv
// Fetch watchdog: counts busy cycles and flags the last permitted cycle.
// Latency: expire is decoded from the count register, asserted during the TIMEOUT_CYC-th enabled cycle.
// Backpressure: none; counter saturates at its terminal value until cleared.
module ysyx_24080014_ifu_wdog #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign expire = en && (cnt == LAST);

    // Count enabled cycles, hold at the terminal value, clear on request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ysyx_24080014_ifu.sv
// Instruction fetch unit: reads the word at pc over an AXI-lite read channel and hands it to the IDU.
// Latency: 2 cycles from ADDR entry to inst_valid on a zero-wait bus; timeout after TIMEOUT_CYC busy cycles.
// Backpressure: holds inst until inst_ready, then idles until commit. Optional YSYX_24080014_IFU_ALIGN_CHK_EN.
module ysyx_24080014_ifu
    import ysyx_24080014_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        commit,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fetch_err
);

    ifu_state_t state;
    logic       start;
    logic       wd_en;
    logic       wd_clr;
    logic       wd_expire;

`ifdef YSYX_24080014_IFU_ALIGN_CHK_EN
    // low pc bits of the current request; araddr itself is always word aligned
    logic [1:0] req_lo;
`endif

    // A new fetch begins right after reset and after each retirement
    assign start  = (state == IFU_IDLE) || ((state == IFU_WAIT) && commit);
    assign wd_en  = (state == IFU_ADDR) || (state == IFU_DATA);
    assign wd_clr = (state == IFU_HOLD);

    ysyx_24080014_ifu_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    // Fetch sequencer; every output is a register updated on state transitions
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IFU_IDLE;
            araddr     <= '0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
`ifdef YSYX_24080014_IFU_ALIGN_CHK_EN
            req_lo     <= 2'b00;
`endif
        end else begin
            case (state)
                IFU_IDLE, IFU_WAIT: begin
                    if (start) begin
                        state   <= IFU_ADDR;
                        araddr  <= fetch_addr(pc);
`ifdef YSYX_24080014_IFU_ALIGN_CHK_EN
                        req_lo  <= pc[1:0];
                        arvalid <= (pc[1:0] == 2'b00);
`else
                        arvalid <= 1'b1;
`endif
                    end
                end
                IFU_ADDR: begin
`ifdef YSYX_24080014_IFU_ALIGN_CHK_EN
                    if (req_lo != 2'b00) begin
                        // misaligned: no bus request, report the original pc
                        state      <= IFU_HOLD;
                        arvalid    <= 1'b0;
                        inst       <= NOP_INST;
                        inst_pc    <= {araddr[31:2], req_lo};
                        fetch_err  <= 1'b1;
                        inst_valid <= 1'b1;
                    end else
`endif
                    if (wd_expire) begin
                        state      <= IFU_HOLD;
                        arvalid    <= 1'b0;
                        inst       <= NOP_INST;
                        inst_pc    <= araddr;
                        fetch_err  <= 1'b1;
                        inst_valid <= 1'b1;
                    end else if (arready) begin
                        state   <= IFU_DATA;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                IFU_DATA: begin
                    // timeout wins over a response arriving in the same cycle
                    if (wd_expire) begin
                        state      <= IFU_HOLD;
                        rready     <= 1'b0;
                        inst       <= NOP_INST;
                        inst_pc    <= araddr;
                        fetch_err  <= 1'b1;
                        inst_valid <= 1'b1;
                    end else if (rvalid) begin
                        state      <= IFU_HOLD;
                        rready     <= 1'b0;
                        inst       <= (rresp == RESP_OKAY) ? rdata : NOP_INST;
                        inst_pc    <= araddr;
                        fetch_err  <= (rresp != RESP_OKAY);
                        inst_valid <= 1'b1;
                    end
                end
                IFU_HOLD: begin
                    if (inst_ready) begin
                        state      <= IFU_WAIT;
                        inst_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IFU_IDLE;
                end
            endcase
        end
    end

    // Retirement can only legally be signalled for the instruction already handed over
    a_commit_in_wait: assert property (@(posedge clk) disable iff (!rst) commit |-> (state == IFU_WAIT));

endmodule
